// File: rtl/mem_bus_pkg.sv
// Shared encodings for the CPU-to-SRAM bus controller: access sizes, FSM states,
// byte-enable constants and little-endian lane helpers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_WORD_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_half(size_e s);
    return s == SIZE_HALF;
  endfunction

  // Encoding 11 behaves exactly like a word access.
  function automatic logic is_word(size_e s);
    return (s == SIZE_WORD) || (s == SIZE_WORD_X);
  endfunction

  function automatic logic misaligned(size_e s, logic [1:0] off);
    return (is_half(s) && off[0]) || (is_word(s) && (off != 2'b00));
  endfunction

  function automatic logic [1:0] align_off(size_e s, logic [1:0] off);
    if (is_word(s)) return 2'b00;
    if (is_half(s)) return {off[1], 1'b0};
    return off;
  endfunction

  function automatic logic [3:0] lane_be(size_e s, logic [1:0] off);
    if (is_word(s)) return BE_WORD;
    if (is_half(s)) return off[1] ? BE_HALF_HI : BE_HALF_LO;
    return BE_BYTE0 << off;
  endfunction

  function automatic logic [31:0] lane_wdata(size_e s, logic [31:0] d);
    if (is_word(s)) return d;
    if (is_half(s)) return {2{d[15:0]}};
    return {4{d[7:0]}};
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half/word lane of an SRAM read word and
// sign- or zero-extends it to 32 bits.
module load_formatter
  import mem_bus_pkg::*;
(
  input  logic [31:0] rdata,
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    data      = rdata;
    byte_lane = 8'(rdata >> {offset, 3'b000});
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    if (is_half(size)) begin
      data = {{16{sign_ext & half_lane[15]}}, half_lane};
    end else if (!is_word(size)) begin
      data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding CPU load/store controller for a synchronous-read SRAM.
// Define MEM_BUS_ALIGN_CHECK_EN to fault misaligned accesses instead of aligning them.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  state_e            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              access_q;
  logic              we_q;
  logic              signed_q;
  size_e             size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_data;

  size_e       req_size_e;
  logic [1:0]  req_off;
  logic        req_bad;
  logic        unused_addr_bits;

  assign req_size_e       = size_e'(req_size);
  assign req_off          = align_off(req_size_e, req_addr[1:0]);
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

`ifdef MEM_BUS_ALIGN_CHECK_EN
  assign req_bad = misaligned(req_size_e, req_addr[1:0]);
`else
  assign req_bad = 1'b0;
`endif

  // The select is gated by reset so an access in flight cannot write the SRAM
  // while reset is asserted; every other strobe follows the gated select.
  assign mem_cs    = access_q & RST;
  assign mem_we    = mem_cs & we_q;
  assign mem_addr  = mem_cs ? addr_q[ADDR_W+1:2] : '0;
  assign mem_be    = mem_cs ? lane_be(size_q, addr_q[1:0]) : BE_NONE;
  assign mem_wdata = mem_cs ? lane_wdata(size_q, wdata_q) : '0;

  load_formatter u_load_formatter (
    .rdata    (mem_rdata),
    .size     (size_q),
    .offset   (addr_q[1:0]),
    .sign_ext (signed_q),
    .data     (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      access_q  <= 1'b0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= SIZE_BYTE;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size_e;
            addr_q    <= {req_addr[ADDR_W+1:2], req_off};
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state    <= ACCESS;
              access_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          access_q <= 1'b0;
          wait_cnt <= CNT_W'(WAIT_STATES - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_rdata <= we_q ? '0 : load_data;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a WAIT_STATES=1 instance and a WAIT_STATES=3
// instance, each backed by a behavioural synchronous-read SRAM.
module tb_mem_bus_ctrl;

  // Sample 0 is taken #1 after the accepting edge, i.e. in cycle t+1, so a
  // response in cycle t+2+WAIT_STATES shows up at sample index WAIT_STATES+1.
  localparam int LAT1 = 2;
  localparam int LAT3 = 4;

  logic        CLK;
  logic        RST;

  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_cs, mem_we;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  logic        req_valid3, req_ready3, req_we3, req_signed3;
  logic [31:0] req_addr3, req_wdata3;
  logic [1:0]  req_size3;
  logic        rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;
  logic        mem_cs3, mem_we3;
  logic [11:0] mem_addr3;
  logic [3:0]  mem_be3;
  logic [31:0] mem_wdata3, mem_rdata3;

  logic [31:0] sram  [0:4095];
  logic [31:0] sram3 [0:4095];

  int checks   = 0;
  int failures = 0;

  logic [31:0] r_rdata, r_mwdata;
  logic        r_err, r_mwe;
  logic [3:0]  r_be;
  logic [11:0] r_maddr;
  int          r_lat, r_cs;

  mem_bus_ctrl #(.ADDR_W(12), .WAIT_STATES(1)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_bus_ctrl #(.ADDR_W(12), .WAIT_STATES(3)) dut3 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3), .req_addr(req_addr3),
    .req_size(req_size3), .req_signed(req_signed3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .mem_cs(mem_cs3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_be(mem_be3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(posedge CLK) begin
    if (mem_cs3) begin
      if (mem_we3) begin
        for (int i = 0; i < 4; i++)
          if (mem_be3[i]) sram3[mem_addr3][8*i +: 8] <= mem_wdata3[8*i +: 8];
      end else begin
        mem_rdata3 <= sram3[mem_addr3];
      end
    end
  end

  // One full transaction on the WAIT_STATES=1 instance; called #1 after an edge in IDLE.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] wdata);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL xact_ready_before got %b exp 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    r_lat = -1; r_cs = 0; r_be = '0; r_maddr = '0; r_mwdata = '0; r_mwe = 1'b0;
    r_rdata = 32'hxxxx_xxxx; r_err = 1'bx;
    for (int n = 0; n < 20 && r_lat < 0; n++) begin
      if (n > 0) begin @(posedge CLK); #1; end
      if (mem_cs) begin
        r_cs++; r_be = mem_be; r_maddr = mem_addr; r_mwdata = mem_wdata; r_mwe = mem_we;
      end
      if (rsp_valid) begin
        r_lat = n; r_rdata = rsp_rdata; r_err = rsp_err;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    checks++; if (mem_cs !== 1'b0) begin failures++; $display("FAIL rst_mem_cs got %b exp 0", mem_cs); end
    checks++; if (mem_be !== 4'b0000) begin failures++; $display("FAIL rst_mem_be got %b exp 0000", mem_be); end
    checks++; if (rsp_valid3 !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid3 got %b exp 0", rsp_valid3); end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (req_ready3 !== 1'b1) begin failures++; $display("FAIL rst_req_ready3 got %b exp 1", req_ready3); end
  endtask

  task automatic test_word;
    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    checks++; if (r_cs !== 1) begin failures++; $display("FAIL word_wr_cs_cycles got %0d exp 1", r_cs); end
    checks++; if (r_mwe !== 1'b1) begin failures++; $display("FAIL word_wr_mem_we got %b exp 1", r_mwe); end
    checks++; if (r_be !== 4'b1111) begin failures++; $display("FAIL word_wr_be got %b exp 1111", r_be); end
    checks++; if (r_maddr !== 12'd4) begin failures++; $display("FAIL word_wr_addr got %0d exp 4", r_maddr); end
    checks++; if (r_mwdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_wr_wdata got %h exp deadbeef", r_mwdata); end
    checks++; if (r_lat !== LAT1) begin failures++; $display("FAIL word_wr_latency got %0d exp %0d", r_lat, LAT1); end
    checks++; if (r_rdata !== 32'h0) begin failures++; $display("FAIL word_wr_rdata got %h exp 0", r_rdata); end
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    checks++; if (r_mwe !== 1'b0) begin failures++; $display("FAIL word_rd_mem_we got %b exp 0", r_mwe); end
    checks++; if (r_be !== 4'b1111) begin failures++; $display("FAIL word_rd_be got %b exp 1111", r_be); end
    checks++; if (r_maddr !== 12'd4) begin failures++; $display("FAIL word_rd_addr got %0d exp 4", r_maddr); end
    checks++; if (r_lat !== LAT1) begin failures++; $display("FAIL word_rd_latency got %0d exp %0d", r_lat, LAT1); end
    checks++; if (r_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rd_rdata got %h exp deadbeef", r_rdata); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL word_rd_err got %b exp 0", r_err); end
  endtask

  task automatic test_byte;
    xact(1'b1, 32'h20, 2'b10, 1'b0, 32'h80A1B2C3);
    xact(1'b0, 32'h23, 2'b00, 1'b1, 32'h0);
    checks++; if (r_be !== 4'b1000) begin failures++; $display("FAIL byte_rd3_be got %b exp 1000", r_be); end
    checks++; if (r_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_rd3_signed got %h exp ffffff80", r_rdata); end
    xact(1'b0, 32'h23, 2'b00, 1'b0, 32'h0);
    checks++; if (r_rdata !== 32'h00000080) begin failures++; $display("FAIL byte_rd3_unsigned got %h exp 00000080", r_rdata); end
    xact(1'b0, 32'h21, 2'b00, 1'b1, 32'h0);
    checks++; if (r_be !== 4'b0010) begin failures++; $display("FAIL byte_rd1_be got %b exp 0010", r_be); end
    checks++; if (r_rdata !== 32'hFFFFFFB2) begin failures++; $display("FAIL byte_rd1_signed got %h exp ffffffb2", r_rdata); end
    xact(1'b1, 32'h22, 2'b00, 1'b0, 32'hFFFFFF5A);
    checks++; if (r_be !== 4'b0100) begin failures++; $display("FAIL byte_wr2_be got %b exp 0100", r_be); end
    checks++; if (r_mwdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL byte_wr2_wdata got %h exp 5a5a5a5a", r_mwdata); end
    xact(1'b0, 32'h20, 2'b11, 1'b0, 32'h0);
    checks++; if (r_be !== 4'b1111) begin failures++; $display("FAIL size11_be got %b exp 1111", r_be); end
    checks++; if (r_rdata !== 32'h805AB2C3) begin failures++; $display("FAIL byte_wr2_readback got %h exp 805ab2c3", r_rdata); end
  endtask

  task automatic test_half;
    xact(1'b1, 32'h10, 2'b10, 1'b0, 32'h1234CAFE);
    xact(1'b1, 32'h12, 2'b01, 1'b0, 32'h0000BEEF);
    checks++; if (r_be !== 4'b1100) begin failures++; $display("FAIL half_wr_be got %b exp 1100", r_be); end
    checks++; if (r_mwdata !== 32'hBEEFBEEF) begin failures++; $display("FAIL half_wr_wdata got %h exp beefbeef", r_mwdata); end
    xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    checks++; if (r_rdata !== 32'hBEEFCAFE) begin failures++; $display("FAIL half_wr_readback got %h exp beefcafe", r_rdata); end
    xact(1'b0, 32'h12, 2'b01, 1'b1, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL half_rd_hi_signed got %h exp ffffbeef", r_rdata); end
    xact(1'b0, 32'h10, 2'b01, 1'b0, 32'h0);
    checks++; if (r_be !== 4'b0011) begin failures++; $display("FAIL half_rd_lo_be got %b exp 0011", r_be); end
    checks++; if (r_rdata !== 32'h0000CAFE) begin failures++; $display("FAIL half_rd_lo_unsigned got %h exp 0000cafe", r_rdata); end
  endtask

  task automatic test_misaligned;
    xact(1'b0, 32'h11, 2'b01, 1'b0, 32'h0);
`ifdef MEM_BUS_ALIGN_CHECK_EN
    checks++; if (r_cs !== 0) begin failures++; $display("FAIL mis_half_cs got %0d exp 0", r_cs); end
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL mis_half_err got %b exp 1", r_err); end
    checks++; if (r_rdata !== 32'h0) begin failures++; $display("FAIL mis_half_rdata got %h exp 0", r_rdata); end
    checks++; if (r_lat !== 0) begin failures++; $display("FAIL mis_half_latency got %0d exp 0", r_lat); end
`else
    checks++; if (r_maddr !== 12'd4) begin failures++; $display("FAIL mis_half_addr got %0d exp 4", r_maddr); end
    checks++; if (r_be !== 4'b0011) begin failures++; $display("FAIL mis_half_be got %b exp 0011", r_be); end
    checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL mis_half_err got %b exp 0", r_err); end
    checks++; if (r_rdata !== 32'h0000CAFE) begin failures++; $display("FAIL mis_half_rdata got %h exp 0000cafe", r_rdata); end
`endif
    xact(1'b0, 32'h13, 2'b10, 1'b0, 32'h0);
`ifdef MEM_BUS_ALIGN_CHECK_EN
    checks++; if (r_cs !== 0) begin failures++; $display("FAIL mis_word_cs got %0d exp 0", r_cs); end
    checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL mis_word_err got %b exp 1", r_err); end
`else
    checks++; if (r_be !== 4'b1111) begin failures++; $display("FAIL mis_word_be got %b exp 1111", r_be); end
    checks++; if (r_rdata !== 32'hBEEFCAFE) begin failures++; $display("FAIL mis_word_rdata got %h exp beefcafe", r_rdata); end
`endif
  endtask

  task automatic test_abort_reset;
    int pulses;
    xact(1'b1, 32'h40, 2'b10, 1'b0, 32'h11111111);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10;
    req_signed = 1'b0; req_wdata = 32'h22222222;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    checks++; if (mem_cs !== 1'b1) begin failures++; $display("FAIL abort_access_cs got %b exp 1", mem_cs); end
    RST = 1'b0;
    #1;
    checks++; if (mem_cs !== 1'b0) begin failures++; $display("FAIL abort_gated_cs got %b exp 0", mem_cs); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_gated_we got %b exp 0", mem_we); end
    pulses = 0;
    @(posedge CLK); #1;
    if (rsp_valid) pulses++;
    @(posedge CLK); #1;
    if (rsp_valid) pulses++;
    RST = 1'b1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_release got %b exp 1", req_ready); end
    for (int n = 0; n < 5; n++) begin
      @(posedge CLK); #1;
      if (rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_rsp_pulses got %0d exp 0", pulses); end
    xact(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
    checks++; if (r_rdata !== 32'h11111111) begin failures++; $display("FAIL abort_sram_unchanged got %h exp 11111111", r_rdata); end
  endtask

  task automatic test_wait3;
    logic [6:0] cs_mask, rsp_mask, rdy_mask;
    int lat3;
    logic [31:0] rd3;
    checks++; if (req_ready3 !== 1'b1) begin failures++; $display("FAIL w3_ready_idle got %b exp 1", req_ready3); end
    req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = 32'h20; req_size3 = 2'b10;
    req_signed3 = 1'b0; req_wdata3 = 32'h12345678;
    cs_mask = '0; rsp_mask = '0; rdy_mask = '0;
    @(posedge CLK); #1;
    for (int n = 0; n < 7; n++) begin
      if (n > 0) begin @(posedge CLK); #1; end
      cs_mask[n]  = mem_cs3;
      rsp_mask[n] = rsp_valid3;
      rdy_mask[n] = req_ready3;
    end
    req_valid3 = 1'b0;
    // Held valid is taken only once IDLE is reached, giving a fresh ACCESS at sample 6.
    checks++; if (cs_mask !== 7'b1000001) begin failures++; $display("FAIL w3_cs_pattern got %b exp 1000001", cs_mask); end
    checks++; if (rsp_mask !== 7'b0010000) begin failures++; $display("FAIL w3_rsp_pattern got %b exp 0010000", rsp_mask); end
    checks++; if (rdy_mask !== 7'b0100000) begin failures++; $display("FAIL w3_ready_pattern got %b exp 0100000", rdy_mask); end
    repeat (8) @(posedge CLK);
    #1;
    req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 32'h20; req_size3 = 2'b10;
    @(posedge CLK); #1;
    req_valid3 = 1'b0;
    lat3 = -1; rd3 = '0;
    for (int n = 0; n < 20 && lat3 < 0; n++) begin
      if (n > 0) begin @(posedge CLK); #1; end
      if (rsp_valid3) begin lat3 = n; rd3 = rsp_rdata3; end
    end
    checks++; if (lat3 !== LAT3) begin failures++; $display("FAIL w3_rd_latency got %0d exp %0d", lat3, LAT3); end
    checks++; if (rd3 !== 32'h12345678) begin failures++; $display("FAIL w3_rd_rdata got %h exp 12345678", rd3); end
  endtask

  initial begin
    RST = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0; req_wdata = '0;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_size3 = '0; req_signed3 = 1'b0; req_wdata3 = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_abort_reset();
    test_wait3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
